// File: rtl/shift_deser.sv
// -----------------------------------------------------------------------------
// shift_deser -- serial-in / parallel-out deserializer
//
// Collects SHIFT_AMOUNT-bit chunks from a serial stream into a SIZE-bit word.
// A frame begins with a chunk flagged by start_i. When the word is complete it
// moves into a registered output stage with a valid/ready handshake. The
// output stage and the shift register are separate, so reception of the next
// frame can continue while the consumer still holds the previous word.
//
// Parameters:
//   SIZE          word width in bits; must be a multiple of SHIFT_AMOUNT
//   SHIFT_AMOUNT  bits accepted per valid cycle
//   MSB_FIRST     1: first chunk ends up in the MSBs, 0: first chunk in the LSBs
//
// Ports:
//   clk_i          clock, rising edge
//   reset_i        synchronous reset, active-high
//   sin_i          serial chunk; sin_i[SHIFT_AMOUNT-1] is its most significant bit
//   sin_valid_i    sin_i carries a chunk this cycle
//   start_i        chunk is the first of a frame (only with sin_valid_i)
//   dout_o         received word (registered)
//   dout_valid_o   dout_o holds a word that has not been consumed
//   dout_ready_i   consumer takes dout_o when dout_valid_o is high
//   busy_o         a frame is being received
//   overrun_o      one-cycle pulse: a completed word was dropped
//   parity_err_o   (SHIFT_DESER_PARITY_EN only) even-parity check failed for
//                  the word in dout_o; valid together with dout_valid_o
//
// Build option:
//   SHIFT_DESER_PARITY_EN  each frame carries one extra even-parity bit after
//                          the data bits (requires SHIFT_AMOUNT == 1). The word
//                          is delivered after the parity bit, with parity_err_o.
// -----------------------------------------------------------------------------
module shift_deser #(
    parameter int unsigned SIZE         = 8,
    parameter int unsigned SHIFT_AMOUNT = 1,
    parameter bit          MSB_FIRST    = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [SHIFT_AMOUNT-1:0] sin_i,
    input  logic                    sin_valid_i,
    input  logic                    start_i,
    output logic [SIZE-1:0]         dout_o,
    output logic                    dout_valid_o,
    input  logic                    dout_ready_i,
    output logic                    busy_o,
    output logic                    overrun_o
`ifdef SHIFT_DESER_PARITY_EN
    ,
    output logic                    parity_err_o
`endif
);

    localparam int unsigned CntW = $clog2(SIZE + 1);

    localparam logic [CntW-1:0] ChunkCnt = CntW'(SHIFT_AMOUNT);
    localparam logic [CntW-1:0] FullCnt  = CntW'(SIZE);
    localparam logic [CntW-1:0] LastCnt  = CntW'(SIZE - SHIFT_AMOUNT);

    typedef enum logic [1:0] {
        StIdle,
        StShift
`ifdef SHIFT_DESER_PARITY_EN
        ,
        StParity
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic [SIZE-1:0] sreg_q;
    logic [SIZE-1:0] dout_q;
    logic            dout_valid_q;
    logic            busy_q;
    logic            overrun_q;
`ifdef SHIFT_DESER_PARITY_EN
    logic            perr_q;
`endif

    // Chunk handling for the current cycle.
    logic            last_chunk;
    logic            restart;
    logic            accept;
    logic            word_done;
    logic [CntW-1:0] cnt_next;
    logic [SIZE-1:0] shift_base;
    logic [SIZE-1:0] shifted;

    // Word hand-off to the output stage.
    logic            deliver;
    logic [SIZE-1:0] deliver_word;
    logic            deliver_perr;
    logic            can_load;

    // A restart shifts the new chunk into an all-zero register, which puts it
    // exactly where a first chunk belongs for either bit order.
    assign shift_base = restart ? '0 : sreg_q;

    if (SIZE == SHIFT_AMOUNT) begin : g_single_chunk
        assign shifted = sin_i;
    end else if (MSB_FIRST) begin : g_msb_first
        assign shifted = {shift_base[SIZE-1-SHIFT_AMOUNT:0], sin_i};
    end else begin : g_lsb_first
        assign shifted = {sin_i, shift_base[SIZE-1:SHIFT_AMOUNT]};
    end

    always_comb begin
        // The chunk that completes a frame is never treated as a start.
        last_chunk = (state_q == StShift) && (cnt_q == LastCnt);
        restart    = sin_valid_i && start_i && !last_chunk;
        accept     = sin_valid_i && (restart || (state_q == StShift));
        cnt_next   = restart ? ChunkCnt : cnt_q + ChunkCnt;
        word_done  = accept && (cnt_next == FullCnt);

`ifdef SHIFT_DESER_PARITY_EN
        // Data complete -> wait for the parity bit; the word goes out with it.
        deliver      = sin_valid_i && !start_i && (state_q == StParity);
        deliver_word = sreg_q;
        deliver_perr = (^sreg_q) ^ sin_i[0];
`else
        deliver      = word_done;
        deliver_word = shifted;
        deliver_perr = 1'b0;
`endif

        can_load = !dout_valid_q || dout_ready_i;

        state_d = state_q;
        if (accept) begin
            if (word_done) begin
`ifdef SHIFT_DESER_PARITY_EN
                state_d = StParity;
`else
                state_d = StIdle;
`endif
            end else begin
                state_d = StShift;
            end
        end else if (deliver) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            sreg_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
            perr_q       <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            // Busy covers every state in which a frame is still open.
            busy_q    <= (state_d != StIdle);
            overrun_q <= 1'b0;

            if (accept) begin
                sreg_q <= shifted;
                cnt_q  <= word_done ? '0 : cnt_next;
            end

            if (deliver) begin
                if (can_load) begin
                    // Covers both an empty stage and a same-cycle consume+load.
                    dout_q       <= deliver_word;
                    dout_valid_q <= 1'b1;
`ifdef SHIFT_DESER_PARITY_EN
                    perr_q       <= deliver_perr;
`endif
                end else begin
                    // Consumer still holds the previous word: keep it, drop this one.
                    overrun_q <= 1'b1;
                end
            end else if (dout_valid_q && dout_ready_i) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

`ifndef SHIFT_DESER_PARITY_EN
    // Only meaningful when the parity option is built in.
    logic unused_perr;
    assign unused_perr = deliver_perr;
`endif

    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign busy_o       = busy_q;
    assign overrun_o    = overrun_q;
`ifdef SHIFT_DESER_PARITY_EN
    assign parity_err_o = perr_q;
`endif

endmodule
